// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus memory-side responder.
// Contents:
//   - read/write encodings as driven by the CPU (read = 0, write = 1)
//   - responder FSM state encodings
//   - offsets of the three registers in the memory-mapped I/O block
//   - data returned for reads of unmapped space
//   - address-region type and captured-request record used by the responder
package cpu_bus_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    localparam logic [1:0] IO_OFS_OUT    = 2'd0;
    localparam logic [1:0] IO_OFS_IN     = 2'd1;
    localparam logic [1:0] IO_OFS_STATUS = 2'd2;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

    typedef enum logic [1:0] {
        REGION_RAM      = 2'd0,
        REGION_IO       = 2'd1,
        REGION_UNMAPPED = 2'd2
    } region_e;

    typedef struct packed {
        logic [15:0] addr;
        logic        read_write;
        logic [7:0]  wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_responder_if.sv
// CPU-side request/response bundle for the bus responder.
// Signals:
//   req        - access request, held by the master until ready
//   addr       - byte address
//   read_write - 0 = read, 1 = write
//   wdata      - write data
//   rdata      - read data, valid while ready is high
//   ready      - one-cycle completion pulse
// Modports: master (CPU side), slave (responder side).
interface bus_responder_if;
    logic        req;
    logic [15:0] addr;
    logic        read_write;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready;

    modport master (
        output req, addr, read_write, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, addr, read_write, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/bus_ram.sv
// Single-port synchronous byte RAM, depth 2^AW.
// Ports:
//   clk   - clock
//   we    - write enable, stores wdata at addr on the rising edge
//   addr  - word address
//   wdata - write data
//   rdata - registered read data (old contents on a same-cycle write)
// Contents are not reset.
module bus_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1 << AW) - 1];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the CPU bus.
// Decodes each captured request into internal RAM, a 3-byte I/O block at
// IO_BASE (output latch, input port, status) or unmapped space, waits
// WAIT_CYCLES cycles, performs the access on the edge entering RESPOND and
// pulses ready for one cycle.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   bus    - request/response bundle (slave side)
//   io_in  - external input port, sampled on the access edge
//   io_out - external output latch
//   fault  - sticky unmapped-access flag, cleared by writing the status reg
module bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int          RAM_AW      = 11,
    parameter logic [15:0] IO_BASE     = 16'hD000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    bus_responder_if.slave bus,
    input  logic [7:0] io_in,
    output logic [7:0] io_out,
    output logic       fault
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    bus_req_t    req_reg;
    bus_req_t    cur_req;
    logic        enter_respond;

    logic        ready_reg;
    logic [7:0]  rdata_reg;
    logic        rdata_from_ram_reg;
    logic [7:0]  io_out_reg;
    logic        fault_reg;
    logic        fault_set, fault_clr;

    region_e     region;
    logic [15:0] io_off16;
    logic [1:0]  io_ofs;

    logic        ram_we;
    logic [7:0]  ram_rdata;

    // With WAIT_CYCLES=0 the access happens on the same edge that samples the
    // request, so decode must see the live bus inputs while in IDLE and the
    // captured copy afterwards.
    assign cur_req = (state_reg == ST_IDLE)
                   ? bus_req_t'{addr: bus.addr, read_write: bus.read_write, wdata: bus.wdata}
                   : req_reg;

    always_comb begin
        region   = REGION_UNMAPPED;
        io_off16 = cur_req.addr - IO_BASE;
        io_ofs   = io_off16[1:0];
        if (cur_req.addr[15:RAM_AW] == '0) begin
            region = REGION_RAM;
        end else if ((cur_req.addr >= IO_BASE) && (io_off16 < 16'd3)) begin
            region = REGION_IO;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        enter_respond = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    cnt_next = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        state_next    = ST_RESPOND;
                        enter_respond = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                // <= rather than == so a corrupted zero count cannot stall.
                if (cnt_reg <= 4'd1) begin
                    cnt_next      = 4'd0;
                    state_next    = ST_RESPOND;
                    enter_respond = 1'b1;
                end
            end
            ST_RESPOND: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // rst gating keeps a reset landing on the access edge from committing.
    assign ram_we = enter_respond && !rst && (region == REGION_RAM)
                 && (cur_req.read_write == RW_WRITE);

    always_comb begin
        fault_set = 1'b0;
        fault_clr = 1'b0;
        if (enter_respond) begin
            if (region == REGION_UNMAPPED) begin
                fault_set = 1'b1;
            end else if ((region == REGION_IO) && (io_ofs == IO_OFS_STATUS)
                         && (cur_req.read_write == RW_WRITE)) begin
                fault_clr = 1'b1;
            end
        end
    end

    bus_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur_req.addr[RAM_AW-1:0]),
        .wdata (cur_req.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            cnt_reg            <= 4'd0;
            req_reg            <= '0;
            ready_reg          <= 1'b0;
            rdata_reg          <= 8'h00;
            rdata_from_ram_reg <= 1'b0;
            io_out_reg         <= 8'h00;
            fault_reg          <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= enter_respond;

            if ((state_reg == ST_IDLE) && bus.req) begin
                req_reg <= cur_req;
            end

            // A RAM read is presented straight from the RAM output register
            // during RESPOND, then copied here so rdata holds afterwards.
            if (rdata_from_ram_reg) begin
                rdata_reg          <= ram_rdata;
                rdata_from_ram_reg <= 1'b0;
            end

            if (enter_respond) begin
                if (cur_req.read_write == RW_WRITE) begin
                    rdata_reg <= 8'h00;
                    if ((region == REGION_IO) && (io_ofs == IO_OFS_OUT)) begin
                        io_out_reg <= cur_req.wdata;
                    end
                end else begin
                    case (region)
                        REGION_RAM: begin
                            rdata_from_ram_reg <= 1'b1;
                        end
                        REGION_IO: begin
                            case (io_ofs)
                                IO_OFS_OUT:    rdata_reg <= io_out_reg;
                                IO_OFS_IN:     rdata_reg <= io_in;
                                IO_OFS_STATUS: rdata_reg <= {7'b0, fault_reg};
                                default:       rdata_reg <= UNMAPPED_DATA;
                            endcase
                        end
                        default: begin
                            rdata_reg <= UNMAPPED_DATA;
                        end
                    endcase
                end
            end

            // Set has priority over clear.
            fault_reg <= fault_set | (fault_reg & ~fault_clr);
        end
    end

    assign bus.ready = ready_reg;
    assign bus.rdata = rdata_from_ram_reg ? ram_rdata : rdata_reg;
    assign io_out    = io_out_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_bus_responder.sv
// Testbench for bus_responder: three instances with WAIT_CYCLES 1, 0 and 3,
// directed accesses followed by randomized ones, checked against a
// behavioural model of the address map.
module tb_bus_responder;

    localparam int ND = 3;

    logic        clk;
    logic        rst;
    logic        req_a     [ND];
    logic [15:0] addr_a    [ND];
    logic        rw_a      [ND];
    logic [7:0]  wdata_a   [ND];
    logic [7:0]  rdata_a   [ND];
    logic        ready_a   [ND];
    logic [7:0]  io_in_a   [ND];
    logic [7:0]  io_out_a  [ND];
    logic        fault_a   [ND];

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
            bus_responder_if bif ();
            assign bif.req        = req_a[gi];
            assign bif.addr       = addr_a[gi];
            assign bif.read_write = rw_a[gi];
            assign bif.wdata      = wdata_a[gi];
            assign rdata_a[gi]    = bif.rdata;
            assign ready_a[gi]    = bif.ready;

            bus_responder #(
                .RAM_AW      (11),
                .IO_BASE     (16'hD000),
                .WAIT_CYCLES (gi == 0 ? 1 : (gi == 1 ? 0 : 3))
            ) u_dut (
                .clk    (clk),
                .rst    (rst),
                .bus    (bif.slave),
                .io_in  (io_in_a[gi]),
                .io_out (io_out_a[gi]),
                .fault  (fault_a[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: byte memory plus the three I/O registers.
    logic [7:0] m_mem    [ND][2048];
    bit         m_valid  [ND][2048];
    logic [7:0] m_io_out [ND];
    bit         m_fault  [ND];
    logic [7:0] m_rdata  [ND];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_io_out[d] = 8'h00;
            m_fault[d]  = 1'b0;
            m_rdata[d]  = 8'h00;
        end
    endtask

    task automatic model_access(input int d, input logic rw, input logic [15:0] a,
                                input logic [7:0] wd, input logic [7:0] iin);
        int idx;
        idx = int'(a[10:0]);
        if (rw) m_rdata[d] = 8'h00;
        if (a <= 16'h07FF) begin
            if (rw) begin
                m_mem[d][idx]   = wd;
                m_valid[d][idx] = 1'b1;
            end else begin
                m_rdata[d] = m_mem[d][idx];
            end
        end else if (a == 16'hD000) begin
            if (rw) m_io_out[d] = wd;
            else    m_rdata[d]  = m_io_out[d];
        end else if (a == 16'hD001) begin
            if (!rw) m_rdata[d] = iin;
        end else if (a == 16'hD002) begin
            if (rw) m_fault[d] = 1'b0;
            else    m_rdata[d] = {7'b0, m_fault[d]};
        end else begin
            m_fault[d] = 1'b1;
            if (!rw) m_rdata[d] = 8'hFF;
        end
    endtask

    task automatic do_access(input int d, input logic rw, input logic [15:0] a,
                             input logic [7:0] wd, input logic [7:0] iin);
        int lat;
        lat = 0;
        @(negedge clk);
        req_a[d]   = 1'b1;
        addr_a[d]  = a;
        rw_a[d]    = rw;
        wdata_a[d] = wd;
        io_in_a[d] = iin;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (c == 1) begin
                // Request inputs must be ignored once captured.
                addr_a[d]  = 16'($urandom);
                wdata_a[d] = 8'($urandom);
                rw_a[d]    = 1'($urandom);
            end
            if (ready_a[d]) begin
                lat = c;
                break;
            end
            @(posedge clk);
        end
        model_access(d, rw, a, wd, iin);
        $display("dut%0d %s addr=%04h wdata=%02h rdata=%02h io_out=%02h fault=%0d ready_cycle=%0d",
                 d, rw ? "WR" : "RD", a, wd, rdata_a[d], io_out_a[d], fault_a[d], lat);
        check($sformatf("d%0d_latency_%04h", d, a), lat, wait_of(d) + 1);
        check($sformatf("d%0d_rdata_%04h", d, a), rdata_a[d], m_rdata[d]);
        check($sformatf("d%0d_io_out_%04h", d, a), io_out_a[d], m_io_out[d]);
        check($sformatf("d%0d_fault_%04h", d, a), fault_a[d], m_fault[d]);
        req_a[d] = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("d%0d_ready_single_%04h", d, a), ready_a[d], 1'b0);
        check($sformatf("d%0d_rdata_hold_%04h", d, a), rdata_a[d], m_rdata[d]);
    endtask

    task automatic hold_test(input int d);
        int prev, npulse, w, exp_pulses;
        w = wait_of(d);
        prev = 0;
        npulse = 0;
        @(negedge clk);
        req_a[d]   = 1'b1;
        addr_a[d]  = 16'h0001;
        rw_a[d]    = 1'b0;
        wdata_a[d] = 8'h00;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            #1;
            if (ready_a[d]) begin
                npulse++;
                $display("dut%0d RD addr=0001 held-req pulse at cycle %0d rdata=%02h", d, c, rdata_a[d]);
                if (npulse == 1) check($sformatf("d%0d_hold_first", d), c, w + 1);
                else             check($sformatf("d%0d_hold_gap", d), c - prev, w + 2);
                check($sformatf("d%0d_hold_rdata", d), rdata_a[d], m_mem[d][1]);
                prev = c;
            end
            @(posedge clk);
        end
        #1;
        req_a[d] = 1'b0;
        exp_pulses = (30 - (w + 1)) / (w + 2) + 1;
        check($sformatf("d%0d_hold_count", d), npulse, exp_pulses);
        repeat (w + 3) @(posedge clk);
        m_rdata[d] = m_mem[d][1];
    endtask

    task automatic random_ops(input int d, input int n);
        int kind, idx;
        logic rw;
        logic [15:0] a;
        logic [7:0] wd, iin;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            rw   = 1'($urandom_range(0, 1));
            wd   = 8'($urandom);
            iin  = 8'($urandom);
            if (kind < 5) begin
                idx = $urandom_range(0, 15);
                a = (idx < 8) ? 16'(idx) : 16'(16'h07F0 + idx);
                if (!rw && !m_valid[d][int'(a[10:0])]) rw = 1'b1;
            end else if (kind < 8) begin
                a = 16'(16'hD000 + $urandom_range(0, 3));
            end else if (kind == 8) begin
                a = 16'(16'h0800 + $urandom_range(0, 16'h1000));
            end else begin
                a = 16'(16'hD003 + $urandom_range(0, 16'h2FFC));
            end
            do_access(d, rw, a, wd, iin);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            req_a[d]   = 1'b0;
            addr_a[d]  = 16'h0000;
            rw_a[d]    = 1'b0;
            wdata_a[d] = 8'h00;
            io_in_a[d] = 8'h00;
            for (int k = 0; k < 2048; k++) begin
                m_mem[d][k]   = 8'h00;
                m_valid[d][k] = 1'b0;
            end
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_reset_ready", d), ready_a[d], 1'b0);
            check($sformatf("d%0d_reset_rdata", d), rdata_a[d], 8'h00);
            check($sformatf("d%0d_reset_io_out", d), io_out_a[d], 8'h00);
            check($sformatf("d%0d_reset_fault", d), fault_a[d], 1'b0);
        end

        // RAM write/read, WAIT_CYCLES = 1
        do_access(0, 1'b1, 16'h0123, 8'h5A, 8'h00);
        do_access(0, 1'b0, 16'h0123, 8'h00, 8'h00);
        // Top RAM byte, WAIT_CYCLES = 0 and 3
        do_access(1, 1'b1, 16'h07FF, 8'hC3, 8'h00);
        do_access(1, 1'b0, 16'h07FF, 8'h00, 8'h00);
        do_access(2, 1'b1, 16'h07FF, 8'hC3, 8'h00);
        do_access(2, 1'b0, 16'h07FF, 8'h00, 8'h00);

        // I/O block
        do_access(0, 1'b1, 16'hD000, 8'hA5, 8'h00);
        do_access(0, 1'b0, 16'hD001, 8'h00, 8'h3C);
        do_access(0, 1'b1, 16'hD001, 8'h11, 8'h3C);
        do_access(0, 1'b0, 16'hD000, 8'h00, 8'h00);

        // Unmapped and status register
        do_access(0, 1'b0, 16'h0800, 8'h00, 8'h00);
        do_access(0, 1'b0, 16'hD002, 8'h00, 8'h00);
        do_access(0, 1'b1, 16'hD002, 8'h00, 8'h00);
        do_access(0, 1'b1, 16'hD003, 8'h99, 8'h00);
        do_access(0, 1'b0, 16'h0003, 8'h00, 8'h00);

        // Reset during the wait state of a write
        do_access(0, 1'b1, 16'h0010, 8'h33, 8'h00);
        @(negedge clk);
        req_a[0]   = 1'b1;
        addr_a[0]  = 16'h0010;
        rw_a[0]    = 1'b1;
        wdata_a[0] = 8'h77;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        req_a[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        $display("dut0 WR addr=0010 wdata=77 abandoned by reset");
        check("d0_rst_mid_ready", ready_a[0], 1'b0);
        check("d0_rst_mid_io_out", io_out_a[0], 8'h00);
        check("d0_rst_mid_fault", fault_a[0], 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("d0_rst_mid_no_ready", ready_a[0], 1'b0);
        end
        do_access(0, 1'b0, 16'h0010, 8'h00, 8'h00);

        // Back-to-back requests with req held high
        for (int d = 0; d < ND; d++) begin
            do_access(d, 1'b1, 16'h0001, 8'(8'h40 + d), 8'h00);
            hold_test(d);
        end

        // Randomized traffic
        for (int d = 0; d < ND; d++) begin
            random_ops(d, 40);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
